// File: rtl/serdiv_wb_core.sv
// Wishbone-slave serial divider: unsigned restoring division, one quotient bit per clock,
// plus a free-running hw blinky, a software LED bit and a logic-analyser view of the working quotient.
module serdiv_wb_core #(
  parameter int WBW     = 32,
  parameter int LAW     = 32,
  parameter int XLEN    = 32,
  parameter int BLINK_W = 24
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [WBW/8-1:0]   wbs_sel_i,
  input  logic [WBW-1:0]     wbs_adr_i,
  input  logic [WBW-1:0]     wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [WBW-1:0]     wbs_dat_o,
  output logic [LAW-1:0]     la_data_o,
  output logic               hw_blinky_o,
  output logic               sw_blinky_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [XLEN-1:0]    dividend, divisor, quotient, remainder;
  logic [XLEN-1:0]    div_s, q_w, rem_w;
  logic [CW-1:0]      count;
  logic               busy, done, dbz, sw_led;
  logic [BLINK_W-1:0] blink_cnt;

  logic               access, commit, start_req;
  logic [2:0]         reg_sel;
  logic [WBW-1:0]     rd_dat;
  logic [XLEN:0]      r_shift, r_next;
  logic [XLEN-1:0]    q_next;
  logic               ge;
  logic               unused_bits;

  function automatic logic [WBW-1:0] merge(input logic [WBW-1:0] old_v,
                                           input logic [WBW-1:0] new_v,
                                           input logic [WBW/8-1:0] sel);
    logic [WBW-1:0] res;
    res = old_v;
    for (int i = 0; i < WBW/8; i++)
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  // Request is taken when ack is low; the write itself lands at the end of the ack cycle.
  assign access    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign commit    = wbs_stb_i & wbs_cyc_i & wbs_ack_o & wbs_we_i;
  assign reg_sel   = wbs_adr_i[4:2];
  assign start_req = commit && (reg_sel == 3'd2) && wbs_sel_i[0] && wbs_dat_i[0];

  assign unused_bits = ^{wbs_adr_i[WBW-1:5], wbs_adr_i[1:0], r_next[XLEN]};

  always_comb begin
    rd_dat = '0;
    case (reg_sel)
      3'd0:    rd_dat = WBW'(dividend);
      3'd1:    rd_dat = WBW'(divisor);
      3'd2:    rd_dat = WBW'({sw_led, dbz, done, busy});
      3'd3:    rd_dat = WBW'(quotient);
      3'd4:    rd_dat = WBW'(remainder);
      3'd5:    rd_dat = WBW'(sw_led);
      default: rd_dat = '0;
    endcase
  end

  // Partial remainder never exceeds the divisor, so one extra bit suffices for the compare.
  always_comb begin
    r_shift = {rem_w, q_w[XLEN-1]};
    ge      = (r_shift >= {1'b0, div_s});
    r_next  = ge ? (r_shift - {1'b0, div_s}) : r_shift;
    q_next  = {q_w[XLEN-2:0], ge};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      dividend  <= '0;
      divisor   <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_s     <= '0;
      q_w       <= '0;
      rem_w     <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      sw_led    <= 1'b0;
      blink_cnt <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_dat : '0;

      if (commit) begin
        case (reg_sel)
          3'd0:    dividend <= XLEN'(merge(WBW'(dividend), wbs_dat_i, wbs_sel_i));
          3'd1:    divisor  <= XLEN'(merge(WBW'(divisor), wbs_dat_i, wbs_sel_i));
          3'd5:    if (wbs_sel_i[0]) sw_led <= wbs_dat_i[0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            if (divisor == '0) begin
              done      <= 1'b1;
              dbz       <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              q_w       <= '1;
            end else begin
              div_s <= divisor;
              q_w   <= dividend;
              rem_w <= '0;
              count <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
              dbz   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          q_w   <= q_next;
          rem_w <= r_next[XLEN-1:0];
          count <= count + 1'b1;
          if (count == CW'(XLEN - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[XLEN-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign la_data_o   = q_w[LAW-1:0];
  assign hw_blinky_o = blink_cnt[BLINK_W-1];
  assign sw_blinky_o = sw_led;

endmodule
